ysyx_23060072_lsu_stage: RTL and testbench
==========================================

YSYX_23060072_LSU_STAGE -- requirements
Module: ysyx_23060072_lsu_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 lsu_valid_i  in  1  upstream (ex stage) presents an operation.
REQ-004 lsu_ready_o  out  1  stage can accept; an op is accepted when lsu_valid_i && lsu_ready_o.
REQ-005 lsu_op_i  in  5  [4] memory access, [3] store, [2] unsigned load, [1:0] size (00 byte, 01 half, 10 word).
REQ-006 lsu_addr_i  in  32  effective address, or ALU result when [4]=0.
REQ-007 lsu_wdata_i  in  32  store data, right-aligned.
REQ-008 rd_i  in  5  destination register; rd_we_i  in  1  writeback request.
REQ-009 mem_req_o / mem_we_o  out  1 / 1  bus request and write enable; mem_addr_o  out  32  word-aligned address.
REQ-010 mem_wdata_o  out  32  lane-shifted store data; mem_wmask_o  out  4  byte-lane strobes.
REQ-011 mem_gnt_i  in  1  request accepted; mem_rvalid_i  in  1  response; mem_rdata_i  in  32  read word.
REQ-012 wb_flag_o  out  1  one-cycle writeback pulse; wb_addr_o  out  5; wb_data_o  out  32 (consumed combinationally by wb stage).

Function
REQ-013 FSM states IDLE, REQ, WAIT; lsu_ready_o SHALL be 1 only in IDLE.
REQ-014 Non-memory op accepted in cycle N: wb_flag_o=rd_we_i, wb_addr_o=rd_i, wb_data_o=lsu_addr_i in cycle N+1; state stays IDLE.
REQ-015 Memory op accepted: IDLE->REQ; address, size, unsigned, rd, data latched; mem_req_o=1 from the next cycle.
REQ-016 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o SHALL be held stable in REQ until mem_gnt_i=1, then REQ->WAIT and mem_req_o drops.
REQ-017 mem_rvalid_i SHALL be sampled only in WAIT; it never occurs in the gnt cycle; on rvalid WAIT->IDLE.
REQ-018 Load: in the cycle after rvalid, wb_flag_o=latched rd_we, wb_addr_o=rd, wb_data_o=selected lane, zero-extended if unsigned else sign-extended.
REQ-019 Lane select: byte uses addr[1:0], half uses addr[1]; word uses whole word.
REQ-020 Store: wmask byte 0001<<addr[1:0], half 0011<<(2*addr[1]), word 1111; wdata replicated into lanes; wb_flag_o SHALL stay 0.
REQ-021 wb_flag_o SHALL be 1 for exactly one cycle per writeback; wb_addr_o/wb_data_o are don't-care when wb_flag_o=0 but SHALL hold last value.
REQ-022 mem_addr_o = {addr[31:2],2'b00}.

Reset
REQ-023 rst during any state: next cycle state=IDLE, mem_req_o=0, mem_we_o=0, mem_wmask_o=0, wb_flag_o=0, wb_addr_o=0, wb_data_o=0, lsu_ready_o=1.
REQ-024 An mem_rvalid_i arriving after a mid-transaction reset SHALL be ignored (no writeback).

Configuration
REQ-025 Macro YSYX_23060072_LSU_MISALIGN_CHK_EN defined: adds output lsu_misalign_o (1 bit); a half op with addr[0]=1 or word op with addr[1:0]!=0 SHALL issue no bus request, pulse lsu_misalign_o for one cycle after acceptance, produce no writeback, stay IDLE.
REQ-026 Macro undefined: no lsu_misalign_o port; misaligned addresses proceed with the word-aligned mem_addr_o and lane rules of REQ-019/020 (upper lanes truncated).

Verification
REQ-027 ALU op addr=0x1234_5678, rd=5, we=1 -> next cycle wb_flag_o=1, wb_addr_o=5, wb_data_o=0x1234_5678.
REQ-028 LB addr=0x103, rdata=0x80xx_xxxx, gnt 2 cycles late -> mem_addr_o=0x100 stable during stall, wb_data_o=0xFFFF_FF80.
REQ-029 LHU addr=0x202, rdata=0xBEEF_0000 -> wb_data_o=0x0000_BEEF.
REQ-030 SH addr=0x302, wdata=0x0000_ABCD -> mem_wmask_o=1100, mem_wdata_o=0xABCD_ABCD, mem_we_o=1, no wb_flag_o pulse.
REQ-031 rst asserted in WAIT, rvalid next cycle -> no wb_flag_o, lsu_ready_o=1.
REQ-032 With YSYX_23060072_LSU_MISALIGN_CHK_EN: LW addr=0x401 -> mem_req_o stays 0, lsu_misalign_o one-cycle pulse.

Source files
------------

// File: rtl/ysyx_23060072_lsu_stage.sv
// Load/store stage: ALU results pass straight to writeback; memory ops run a REQ/WAIT bus handshake.
// Optional macro YSYX_23060072_LSU_MISALIGN_CHK_EN adds lsu_misalign_o and drops misaligned half/word ops.
module ysyx_23060072_lsu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_op_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  rd_i,
  input  logic        rd_we_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
  output logic        lsu_misalign_o,
`endif
  output logic        wb_flag_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        wb_flag_q, wb_flag_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        go_mem;

  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
  logic misalign;
  logic misalign_q, misalign_d;

  assign misalign = ((lsu_op_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                    (lsu_op_i[1] && (lsu_addr_i[1:0] != 2'b00));
  assign go_mem = lsu_op_i[4] && !misalign;
  assign misalign_d = (state_q == S_IDLE) && lsu_valid_i && lsu_op_i[4] && misalign;
  assign lsu_misalign_o = misalign_q;
`else
  assign go_mem = lsu_op_i[4];
`endif

  // Size 2'b11 is treated as a word access throughout.
  always_comb begin
    st_wdata = lsu_wdata_i;
    st_wmask = 4'b1111;
    case (lsu_op_i[1:0])
      2'b00: begin
        st_wdata = {4{lsu_wdata_i[7:0]}};
        st_wmask = 4'b0001 << lsu_addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{lsu_wdata_i[15:0]}};
        st_wmask = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata_i[7:0];
      2'b01:   ld_byte = mem_rdata_i[15:8];
      2'b10:   ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    store_d   = store_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    wb_flag_d = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          if (!lsu_op_i[4]) begin
            wb_flag_d = rd_we_i;
            if (rd_we_i) begin
              wb_addr_d = rd_i;
              wb_data_d = lsu_addr_i;
            end
          end else if (go_mem) begin
            state_d = S_REQ;
            addr_d  = lsu_addr_i;
            size_d  = lsu_op_i[1:0];
            uns_d   = lsu_op_i[2];
            store_d = lsu_op_i[3];
            rd_d    = rd_i;
            rd_we_d = rd_we_i;
            wdata_d = st_wdata;
            wmask_d = st_wmask;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
          // Stores complete silently; only loads with a write request reach writeback.
          if (!store_q && rd_we_q) begin
            wb_flag_d = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = ld_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      wb_flag_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      store_q   <= store_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      wb_flag_q <= wb_flag_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign lsu_ready_o = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = (state_q == S_REQ) && store_q;
  assign mem_wmask_o = mem_we_o ? wmask_q : 4'b0000;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = wdata_q;
  assign wb_flag_o   = wb_flag_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_ysyx_23060072_lsu_stage.sv
// Randomized self-checking bench for ysyx_23060072_lsu_stage against an arithmetic reference model.
module tb_ysyx_23060072_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_op_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [4:0]  rd_i;
  logic        rd_we_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_flag_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
  logic        lsu_misalign_o;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: last written-back register and value
  logic [4:0]  exp_wb_addr;
  logic [31:0] exp_wb_data;

  // Observations captured by the transaction drivers
  logic        o_accept_ready, o_ready_busy, o_req, o_we, o_stable, o_req_after_gnt, o_ready_end, o_flag_after;
  logic [31:0] o_addr, o_wdata, o_wb_data;
  logic [3:0]  o_wmask;
  logic [4:0]  o_wb_addr;
  logic        o_wb_flag;
  int          o_wb_cnt;

  ysyx_23060072_lsu_stage dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_op_i(lsu_op_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .rd_i(rd_i), .rd_we_i(rd_we_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
    .lsu_misalign_o(lsu_misalign_o),
`endif
    .wb_flag_o(wb_flag_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] rdata,
                                             input logic [1:0] size, input logic uns);
    longint unsigned v;
    if (size == 2'd0) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [1:0] size);
    int m;
    if (size == 2'd0)      m = 1 << (addr % 4);
    else if (size == 2'd1) m = 3 << (2 * ((addr / 2) % 2));
    else                   m = 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [1:0] size);
    longint unsigned v;
    if (size == 2'd0)      v = (wdata % 256) * 64'h0101_0101;
    else if (size == 2'd1) v = (wdata % 65536) * 64'h0001_0001;
    else                   v = wdata;
    return v[31:0];
  endfunction

  // Drives one memory transaction with fixed grant/response latencies and records what the DUT showed.
  task automatic run_mem_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic we, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata);
    lsu_valid_i = 1'b1; lsu_op_i = op; lsu_addr_i = addr; lsu_wdata_i = wdata; rd_i = rd; rd_we_i = we;
    o_accept_ready = lsu_ready_o;
    tick();
    lsu_valid_i = 1'b0; lsu_addr_i = $urandom; lsu_wdata_i = $urandom; rd_i = 5'($urandom);
    o_wb_cnt = int'(wb_flag_o);
    o_ready_busy = lsu_ready_o;
    o_req = mem_req_o; o_we = mem_we_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o; o_wmask = mem_wmask_o;
    o_stable = 1'b1;
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      o_wb_cnt += int'(wb_flag_o);
      if (mem_req_o !== o_req || mem_we_o !== o_we || mem_addr_o !== o_addr ||
          mem_wdata_o !== o_wdata || mem_wmask_o !== o_wmask) o_stable = 1'b0;
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    o_req_after_gnt = mem_req_o;
    o_wb_cnt += int'(wb_flag_o);
    for (int i = 0; i < rv_dly; i++) begin
      tick();
      o_wb_cnt += int'(wb_flag_o);
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
    o_wb_flag = wb_flag_o; o_wb_addr = wb_addr_o; o_wb_data = wb_data_o; o_ready_end = lsu_ready_o;
    o_wb_cnt += int'(wb_flag_o);
    tick();
    o_wb_cnt += int'(wb_flag_o);
  endtask

  task automatic run_alu(input logic [31:0] addr, input logic [4:0] rd, input logic we);
    lsu_valid_i = 1'b1; lsu_op_i = {2'b00, 3'($urandom)}; lsu_addr_i = addr; rd_i = rd; rd_we_i = we;
    o_accept_ready = lsu_ready_o;
    tick();
    lsu_valid_i = 1'b0;
    o_wb_flag = wb_flag_o; o_wb_addr = wb_addr_o; o_wb_data = wb_data_o; o_ready_end = lsu_ready_o;
    tick();
    o_flag_after = wb_flag_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_cmp++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_ready got %b exp 1", lsu_ready_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req got %b exp 0", mem_req_o); end
    n_cmp++; if (mem_we_o !== 1'b0 || mem_wmask_o !== 4'b0) begin n_fail++; $display("[TB] FAIL rst_we_mask got %b/%b exp 0/0000", mem_we_o, mem_wmask_o); end
    n_cmp++; if (wb_flag_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wb_flag got %b exp 0", wb_flag_o); end
    n_cmp++; if (wb_addr_o !== 5'd0 || wb_data_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_wb_vals got %h/%h exp 0/0", wb_addr_o, wb_data_o); end
    rst = 1'b0;
    exp_wb_addr = '0; exp_wb_data = '0;
  endtask

  task automatic test_alu;
    logic [31:0] a; logic [4:0] r; logic w;
    run_alu(32'h1234_5678, 5'd5, 1'b1);
    exp_wb_addr = 5'd5; exp_wb_data = 32'h1234_5678;
    n_cmp++; if (o_accept_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_ready got %b exp 1", o_accept_ready); end
    n_cmp++; if (o_wb_flag !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_flag got %b exp 1", o_wb_flag); end
    n_cmp++; if (o_wb_addr !== 5'd5 || o_wb_data !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL alu_wb got %h/%h exp 05/12345678", o_wb_addr, o_wb_data); end
    n_cmp++; if (o_flag_after !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_pulse got %b exp 0", o_flag_after); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; r = 5'($urandom); w = 1'($urandom);
      run_alu(a, r, w);
      if (w) begin exp_wb_addr = r; exp_wb_data = a; end
      n_cmp++; if (o_wb_flag !== w || o_flag_after !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_rand_flag got %b,%b exp %b,0", o_wb_flag, o_flag_after, w); end
      n_cmp++; if (o_wb_addr !== exp_wb_addr || o_wb_data !== exp_wb_data) begin n_fail++; $display("[TB] FAIL alu_rand_wb got %h/%h exp %h/%h", o_wb_addr, o_wb_data, exp_wb_addr, exp_wb_data); end
    end
  endtask

  task automatic test_load_byte;
    run_mem_op(5'b10000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 1, 32'h8012_3456);
    exp_wb_addr = 5'd7; exp_wb_data = 32'hFFFF_FF80;
    n_cmp++; if (o_req !== 1'b1 || o_we !== 1'b0 || o_ready_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL lb_req got req%b we%b rdy%b exp 1 0 0", o_req, o_we, o_ready_busy); end
    n_cmp++; if (o_addr !== 32'h0000_0100) begin n_fail++; $display("[TB] FAIL lb_addr got %h exp 00000100", o_addr); end
    n_cmp++; if (o_stable !== 1'b1) begin n_fail++; $display("[TB] FAIL lb_stall_stable got %b exp 1", o_stable); end
    n_cmp++; if (o_req_after_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL lb_req_drop got %b exp 0", o_req_after_gnt); end
    n_cmp++; if (o_wb_cnt != 1 || o_wb_flag !== 1'b1) begin n_fail++; $display("[TB] FAIL lb_pulse got cnt %0d flag %b exp 1 1", o_wb_cnt, o_wb_flag); end
    n_cmp++; if (o_wb_addr !== 5'd7 || o_wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("[TB] FAIL lb_wb got %h/%h exp 07/ffffff80", o_wb_addr, o_wb_data); end
    n_cmp++; if (o_ready_end !== 1'b1) begin n_fail++; $display("[TB] FAIL lb_ready_end got %b exp 1", o_ready_end); end
  endtask

  task automatic test_load_half_unsigned;
    run_mem_op(5'b10101, 32'h0000_0202, 32'h0, 5'd9, 1'b1, 0, 0, 32'hBEEF_0000);
    exp_wb_addr = 5'd9; exp_wb_data = 32'h0000_BEEF;
    n_cmp++; if (o_addr !== 32'h0000_0200) begin n_fail++; $display("[TB] FAIL lhu_addr got %h exp 00000200", o_addr); end
    n_cmp++; if (o_wb_cnt != 1 || o_wb_data !== 32'h0000_BEEF) begin n_fail++; $display("[TB] FAIL lhu_wb got cnt %0d data %h exp 1 0000beef", o_wb_cnt, o_wb_data); end
  endtask

  task automatic test_store_half;
    run_mem_op(5'b11001, 32'h0000_0302, 32'h0000_ABCD, 5'd3, 1'b1, 1, 0, $urandom);
    n_cmp++; if (o_wmask !== 4'b1100) begin n_fail++; $display("[TB] FAIL sh_mask got %b exp 1100", o_wmask); end
    n_cmp++; if (o_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("[TB] FAIL sh_wdata got %h exp abcdabcd", o_wdata); end
    n_cmp++; if (o_we !== 1'b1 || o_addr !== 32'h0000_0300) begin n_fail++; $display("[TB] FAIL sh_we_addr got %b/%h exp 1/00000300", o_we, o_addr); end
    n_cmp++; if (o_wb_cnt != 0) begin n_fail++; $display("[TB] FAIL sh_no_wb got %0d pulses exp 0", o_wb_cnt); end
    n_cmp++; if (o_wb_addr !== exp_wb_addr || o_wb_data !== exp_wb_data) begin n_fail++; $display("[TB] FAIL sh_wb_hold got %h/%h exp %h/%h", o_wb_addr, o_wb_data, exp_wb_addr, exp_wb_data); end
  endtask

  task automatic test_reset_in_wait;
    int pulses;
    lsu_valid_i = 1'b1; lsu_op_i = 5'b10010; lsu_addr_i = 32'h0000_0500; rd_i = 5'd11; rd_we_i = 1'b1;
    tick();
    lsu_valid_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    pulses = int'(wb_flag_o);
    tick();
    mem_rvalid_i = 1'b0;
    pulses += int'(wb_flag_o);
    n_cmp++; if (lsu_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_state got rdy%b req%b exp 1 0", lsu_ready_o, mem_req_o); end
    tick();
    pulses += int'(wb_flag_o);
    exp_wb_addr = '0; exp_wb_data = '0;
    n_cmp++; if (pulses != 0) begin n_fail++; $display("[TB] FAIL rstwait_no_wb got %0d pulses exp 0", pulses); end
    n_cmp++; if (wb_addr_o !== 5'd0 || wb_data_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rstwait_wb_vals got %h/%h exp 0/0", wb_addr_o, wb_data_o); end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rdat, exp_ld; logic [1:0] sz; logic st, un, w; logic [4:0] r;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; wd = $urandom; rdat = $urandom; r = 5'($urandom); w = 1'($urandom);
      sz = 2'($urandom_range(0, 2)); st = 1'($urandom); un = 1'($urandom);
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
`endif
      run_mem_op({1'b1, st, un, sz}, a, wd, r, w, $urandom_range(0, 3), $urandom_range(0, 3), rdat);
      exp_ld = model_load(a, rdat, sz, un);
      if (!st && w) begin exp_wb_addr = r; exp_wb_data = exp_ld; end
      n_cmp++; if (o_req !== 1'b1 || o_stable !== 1'b1 || o_req_after_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_handshake[%0d] got req%b stable%b drop%b exp 1 1 0", i, o_req, o_stable, o_req_after_gnt); end
      n_cmp++; if (o_addr !== ((a / 4) * 4) || o_we !== st) begin n_fail++; $display("[TB] FAIL rnd_addr_we[%0d] got %h/%b exp %h/%b", i, o_addr, o_we, (a / 4) * 4, st); end
      if (st) begin
        n_cmp++; if (o_wmask !== model_mask(a, sz) || o_wdata !== model_wdata(wd, sz)) begin n_fail++; $display("[TB] FAIL rnd_store[%0d] got %b/%h exp %b/%h", i, o_wmask, o_wdata, model_mask(a, sz), model_wdata(wd, sz)); end
      end
      n_cmp++; if (o_wb_cnt != int'(!st && w)) begin n_fail++; $display("[TB] FAIL rnd_pulses[%0d] got %0d exp %0d", i, o_wb_cnt, int'(!st && w)); end
      n_cmp++; if (o_wb_addr !== exp_wb_addr || o_wb_data !== exp_wb_data) begin n_fail++; $display("[TB] FAIL rnd_wb[%0d] got %h/%h exp %h/%h", i, o_wb_addr, o_wb_data, exp_wb_addr, exp_wb_data); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a; logic [4:0] r; logic w;
    lsu_valid_i = 1'b1; lsu_op_i = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; r = 5'($urandom); w = (i != 3);
      lsu_addr_i = a; rd_i = r; rd_we_i = w;
      tick();
      if (w) begin exp_wb_addr = r; exp_wb_data = a; end
      n_cmp++; if (wb_flag_o !== w || lsu_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_flag[%0d] got %b rdy %b exp %b 1", i, wb_flag_o, lsu_ready_o, w); end
      n_cmp++; if (wb_addr_o !== exp_wb_addr || wb_data_o !== exp_wb_data) begin n_fail++; $display("[TB] FAIL b2b_wb[%0d] got %h/%h exp %h/%h", i, wb_addr_o, wb_data_o, exp_wb_addr, exp_wb_data); end
    end
    lsu_valid_i = 1'b0;
    tick();
    n_cmp++; if (wb_flag_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_flag got %b exp 0", wb_flag_o); end
  endtask

`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
  task automatic test_misalign;
    lsu_valid_i = 1'b1; lsu_op_i = 5'b10010; lsu_addr_i = 32'h0000_0401; rd_i = 5'd4; rd_we_i = 1'b1;
    tick();
    lsu_valid_i = 1'b0;
    n_cmp++; if (lsu_misalign_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_pulse got mis%b req%b exp 1 0", lsu_misalign_o, mem_req_o); end
    n_cmp++; if (lsu_ready_o !== 1'b1 || wb_flag_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_idle got rdy%b wb%b exp 1 0", lsu_ready_o, wb_flag_o); end
    tick();
    n_cmp++; if (lsu_misalign_o !== 1'b0 || mem_req_o !== 1'b0 || wb_flag_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_after got mis%b req%b wb%b exp 0 0 0", lsu_misalign_o, mem_req_o, wb_flag_o); end
  endtask
`endif

  initial begin
    rst = 1'b1; lsu_valid_i = 1'b0; lsu_op_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    rd_i = '0; rd_we_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    exp_wb_addr = '0; exp_wb_data = '0;
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half_unsigned();
    test_store_half();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
`ifdef YSYX_23060072_LSU_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
